// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: size codes, queued request
// layout and FSM state encoding.
package dmem_pkg;

    // Access size codes carried alongside each request (informational).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Word-index field is sized for the widest possible byte address so the
    // struct layout does not depend on the instance's ADDR_W.
    localparam int IDX_W = 30;

    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic [IDX_W-1:0] idx;
        logic [3:0]       sel;
        logic [31:0]      wdata;
    } dmem_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request queue. Pointers carry one extra wrap bit so that full and
// empty can be told apart without a separate occupancy register.
module dmem_req_fifo
    import dmem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  dmem_req_t                din_i,
    output dmem_req_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] MSB_ONLY = PW'(1) << (PW - 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          do_push, do_pop;
    dmem_req_t     store_q [DEPTH];

    // A single-entry queue always uses slot 0; otherwise the low pointer bits
    // address the storage directly.
    generate
        if (DEPTH > 1) begin : g_idx
            assign wr_idx = wr_ptr_q[AW-1:0];
            assign rd_idx = rd_ptr_q[AW-1:0];
        end else begin : g_idx_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end
    endgenerate

    // Full when the wrap bits differ and the index bits match.
    assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == MSB_ONLY);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Head is read combinationally so the FSM sees the oldest request at once.
    assign head_o = store_q[rd_idx];

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; clearing them discards every queued request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: accepts bus requests into an in-order queue,
// services the head after a programmable delay and reports completion with a
// one-cycle data_ok pulse (plus the full word for loads).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o,
    output logic        busy_o
);

    localparam int MW    = ADDR_W - 2;
    localparam int WORDS = 1 << MW;
    localparam int PW    = $clog2(QDEPTH) + 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_req_t     push_req;
    dmem_req_t     head;
    logic          q_full;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;
    logic [PW-1:0] q_count;

    dmem_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          access;
    logic          more;

    logic [MW-1:0] widx;
    logic [3:0]    lane_we;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [WORDS];

    // Pack the bus fields into a queue entry; high address bits simply alias.
    always_comb begin
        push_req       = '0;
        push_req.wr    = wr_i;
        push_req.size  = size_i;
        push_req.idx   = IDX_W'(addr_i[ADDR_W-1:2]);
        push_req.sel   = sel_i;
        push_req.wdata = wdata_i;
    end

    // Acceptance depends only on queue space; no bypass around a full queue.
    assign addr_ok_o = ~q_full;
    assign q_push    = req_i & ~q_full;

    dmem_req_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .din_i   (push_req),
        .head_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Queue stays non-empty after the pop if something is behind the head or
    // a new request lands on the same edge.
    assign more = (q_count > PW'(1)) | q_push;

    // Next-state logic: IDLE -> WAIT (count down) -> RESP (pulse and pop).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        q_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                q_pop = 1'b1;
                if (more) begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign widx = head.idx[MW-1:0];

    // Per-lane write enables for the head store.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = access & head.wr & head.sel[gi];
        end
    endgenerate

    // Byte-enabled memory writes; the array itself keeps its contents on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                mem[widx][i*8 +: 8] <= head.wdata[i*8 +: 8];
            end
        end
    end

    // Registered load data; only a load completion updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (access && !head.wr) begin
            rdata_q <= mem[widx];
        end
    end

    assign data_ok_o = (state_q == RESP);
    assign rdata_o   = rdata_q;
    assign busy_o    = (state_q != IDLE) | ~q_empty;

    // Size code and byte offset are carried but not acted on here; alignment
    // and lane extraction happen in the CPU.
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], head.size, head.idx[IDX_W-1:MW]};

    generate
        if (ADDR_W < 32) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^addr_i[31:ADDR_W];
        end
    endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with different latency/depth,
// driven one at a time, checked against a word-array memory model.
module tb_dmem_responder;

    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_r = 1'b0;
    logic        wr_r = 1'b0;
    logic [1:0]  size_r = 2'b00;
    logic [31:0] addr_r = 32'h0;
    logic [3:0]  sel_r = 4'h0;
    logic [31:0] wdata_r = 32'h0;
    logic [1:0]  dsel = 2'd0;

    logic [2:0]  req_g;
    logic [2:0]  addr_ok_w, data_ok_w, busy_w;
    logic [31:0] rdata_w [3];
    logic        addr_ok_s, data_ok_s, busy_s;
    logic [31:0] rdata_s;

    always #5 clk = ~clk;

    assign req_g     = req_r ? (3'b001 << dsel) : 3'b000;
    assign addr_ok_s = addr_ok_w[dsel];
    assign data_ok_s = data_ok_w[dsel];
    assign busy_s    = busy_w[dsel];
    assign rdata_s   = rdata_w[dsel];

    dmem_responder #(.ADDR_W(AW), .LATENCY(2), .QDEPTH(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_i(req_g[0]), .wr_i(wr_r), .size_i(size_r),
        .addr_i(addr_r), .sel_i(sel_r), .wdata_i(wdata_r),
        .addr_ok_o(addr_ok_w[0]), .data_ok_o(data_ok_w[0]),
        .rdata_o(rdata_w[0]), .busy_o(busy_w[0]));

    dmem_responder #(.ADDR_W(AW), .LATENCY(3), .QDEPTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .req_i(req_g[1]), .wr_i(wr_r), .size_i(size_r),
        .addr_i(addr_r), .sel_i(sel_r), .wdata_i(wdata_r),
        .addr_ok_o(addr_ok_w[1]), .data_ok_o(data_ok_w[1]),
        .rdata_o(rdata_w[1]), .busy_o(busy_w[1]));

    dmem_responder #(.ADDR_W(AW), .LATENCY(1), .QDEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .req_i(req_g[2]), .wr_i(wr_r), .size_i(size_r),
        .addr_i(addr_r), .sel_i(sel_r), .wdata_i(wdata_r),
        .addr_ok_o(addr_ok_w[2]), .data_ok_o(data_ok_w[2]),
        .rdata_o(rdata_w[2]), .busy_o(busy_w[2]));

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
    } exp_t;

    txn_t        txq[$];
    exp_t        expq[$];
    int          pulse_cyc[$];
    int          blocked[$];
    int          blocked_pops;
    logic [31:0] model_mem [int];
    logic [31:0] last_rd [3];
    int          lat_of [3] = '{2, 3, 1};
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model key: instance plus word index from the low AW address bits.
    function automatic int mkey(logic [1:0] d, logic [31:0] a);
        return int'(d) * 65536 + int'(a[AW-1:2]);
    endfunction

    // Apply one request to the model in issue order; returns the rdata the
    // completion must show (load word, or the last load word for a store).
    function automatic logic [31:0] model_access(txn_t t);
        int          k;
        logic [31:0] w;
        k = mkey(dsel, t.addr);
        w = model_mem.exists(k) ? model_mem[k] : 32'h0;
        if (t.wr) begin
            for (int b = 0; b < 4; b++)
                if (t.sel[b]) w[b*8 +: 8] = t.wdata[b*8 +: 8];
            model_mem[k] = w;
            return last_rd[dsel];
        end
        last_rd[dsel] = w;
        return w;
    endfunction

    task automatic add(input logic wr, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata);
        txn_t t;
        t.wr = wr; t.addr = addr; t.sel = sel; t.wdata = wdata;
        t.size = (sel == 4'hF) ? 2'b10 : 2'b00;
        txq.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
    endtask

    // Issue every queued transaction back to back (req held high) and check
    // each data_ok pulse against the model in order.
    task automatic run_seq(input int budget);
        int n;
        int got;
        n   = txq.size();
        got = 0;
        expq.delete();
        pulse_cyc.delete();
        blocked.delete();
        fork
            begin
                logic acc;
                logic chk;
                int   waits;
                logic abort;
                abort = 1'b0;
                chk   = 1'b0;
                for (int i = 0; i < n && !abort; i++) begin
                    req_r = 1'b1; wr_r = txq[i].wr; size_r = txq[i].size;
                    addr_r = txq[i].addr; sel_r = txq[i].sel; wdata_r = txq[i].wdata;
                    acc = 1'b0; waits = 0;
                    while (!acc && !abort) begin
                        if (chk) begin
                            tests_run++;
                            if (addr_ok_s !== 1'b1) begin
                                tests_failed++;
                                $display("FAIL addr_ok_after_pop: got %b expected 1", addr_ok_s);
                            end
                            chk = 1'b0;
                        end
                        acc = addr_ok_s;
                        if (acc) begin
                            expq.push_back('{txq[i].wr, model_access(txq[i])});
                            blocked.push_back(waits);
                        end else if (data_ok_s) begin
                            chk = 1'b1;
                            blocked_pops++;
                        end
                        @(posedge clk); #1;
                        waits++;
                        if (waits > budget) begin
                            tests_run++; tests_failed++;
                            $display("FAIL accept_timeout: req %0d never accepted in %0d cycles", i, budget);
                            abort = 1'b1;
                        end
                    end
                end
                req_r = 1'b0;
            end
            begin
                int   waited;
                exp_t e;
                waited = 0;
                while (got < n && waited < budget) begin
                    @(posedge clk); #1;
                    waited++;
                    if (data_ok_s) begin
                        tests_run++;
                        if (expq.size() == 0) begin
                            tests_failed++;
                            $display("FAIL spurious_data_ok: got pulse at cycle %0d expected none", cyc);
                        end else begin
                            e = expq.pop_front();
                            if (rdata_s !== e.rdata) begin
                                tests_failed++;
                                $display("FAIL rdata: got %h expected %h (wr=%b)", rdata_s, e.rdata, e.wr);
                            end
                            if (pulse_cyc.size() > 0) begin
                                tests_run++;
                                if (cyc - pulse_cyc[$] < lat_of[dsel]) begin
                                    tests_failed++;
                                    $display("FAIL pulse_spacing: got %0d cycles expected >= %0d",
                                             cyc - pulse_cyc[$], lat_of[dsel]);
                                end
                            end
                            pulse_cyc.push_back(cyc);
                            got++;
                        end
                    end
                end
                tests_run++;
                if (got != n) begin
                    tests_failed++;
                    $display("FAIL data_ok_count: got %0d expected %0d", got, n);
                end
            end
        join
        txq.delete();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            tests_run += 4;
            if (addr_ok_w[d] !== 1'b1) begin tests_failed++; $display("FAIL reset_addr_ok[%0d]: got %b expected 1", d, addr_ok_w[d]); end
            if (data_ok_w[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_data_ok[%0d]: got %b expected 0", d, data_ok_w[d]); end
            if (busy_w[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy[%0d]: got %b expected 0", d, busy_w[d]); end
            if (rdata_w[d] !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdata_w[d]); end
        end
        do_reset();
        $display("[TB] test_reset done");
    endtask

    task automatic test_store_load();
        dsel = 2'd0;
        add(1'b1, 32'h100, 4'hF, 32'h12345678);
        add(1'b0, 32'h100, 4'h0, 32'h0);
        run_seq(100);
        tests_run++;
        if (rdata_s !== 32'h12345678) begin tests_failed++; $display("FAIL store_load: got %h expected 12345678", rdata_s); end
        $display("[TB] test_store_load rdata=%h", rdata_s);
    endtask

    task automatic test_byte_merge();
        dsel = 2'd0;
        add(1'b1, 32'h200, 4'hF, 32'hAABBCCDD);
        add(1'b1, 32'h200, 4'b0010, 32'h00001100);
        add(1'b0, 32'h200, 4'h0, 32'h0);
        run_seq(100);
        tests_run++;
        if (rdata_s !== 32'hAABB11DD) begin tests_failed++; $display("FAIL byte_merge: got %h expected aabb11dd", rdata_s); end
        $display("[TB] test_byte_merge rdata=%h", rdata_s);
    endtask

    task automatic test_back_pressure();
        dsel = 2'd1;
        for (int i = 0; i < 4; i++) add(1'b1, 32'h400 + 32'(i*4), 4'hF, $urandom);
        run_seq(200);
        for (int i = 0; i < 4; i++) add(1'b0, 32'h400 + 32'(i*4), 4'h0, 32'h0);
        blocked_pops = 0;
        run_seq(200);
        tests_run += 4;
        if (blocked[0] !== 0) begin tests_failed++; $display("FAIL bp_first: got %0d stall cycles expected 0", blocked[0]); end
        if (blocked[1] !== 0) begin tests_failed++; $display("FAIL bp_second: got %0d stall cycles expected 0", blocked[1]); end
        if (blocked[2] <= 0) begin tests_failed++; $display("FAIL bp_third: got %0d stall cycles expected >0", blocked[2]); end
        if (blocked_pops <= 0) begin tests_failed++; $display("FAIL bp_full_pop: got %0d blocked pops expected >0", blocked_pops); end
        $display("[TB] test_back_pressure stalls=%0d blocked_pops=%0d", blocked[2], blocked_pops);
    endtask

    task automatic test_alias();
        dsel = 2'd0;
        add(1'b1, 32'h00010004, 4'hF, 32'hCAFEF00D);
        add(1'b0, 32'h00000004, 4'h0, 32'h0);
        run_seq(100);
        tests_run++;
        if (rdata_s !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL alias: got %h expected cafef00d", rdata_s); end
        $display("[TB] test_alias rdata=%h", rdata_s);
    endtask

    task automatic test_reset_midflight();
        dsel = 2'd0;
        add(1'b1, 32'h300, 4'hF, 32'h0);
        run_seq(100);
        req_r = 1'b1; wr_r = 1'b1; addr_r = 32'h300; sel_r = 4'hF; wdata_r = 32'hFFFFFFFF;
        tests_run++;
        if (addr_ok_s !== 1'b1) begin tests_failed++; $display("FAIL mid_accept: got %b expected 1", addr_ok_s); end
        @(posedge clk); #1;
        req_r = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (busy_s !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_before: got %b expected 1", busy_s); end
        rst = 1'b1;
        #1;
        tests_run += 3;
        if (addr_ok_s !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_addr_ok: got %b expected 1", addr_ok_s); end
        if (busy_s !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_busy: got %b expected 0", busy_s); end
        if (data_ok_s !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_data_ok: got %b expected 0", data_ok_s); end
        for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst = 1'b0;
            tests_run++;
            if (data_ok_s !== 1'b0) begin tests_failed++; $display("FAIL mid_no_data_ok: got %b expected 0 (cycle %0d)", data_ok_s, c); end
        end
        add(1'b0, 32'h300, 4'h0, 32'h0);
        run_seq(100);
        tests_run++;
        if (rdata_s !== 32'h0) begin tests_failed++; $display("FAIL mid_store_dropped: got %h expected 00000000", rdata_s); end
        $display("[TB] test_reset_midflight rdata=%h", rdata_s);
    endtask

    task automatic test_random();
        dsel = 2'd2;
        for (int i = 0; i < 8; i++) add(1'b1, 32'h800 + 32'(i*4), 4'hF, $urandom);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'h800 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 3) == 0) a = a | 32'h00010000;
            add(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
        end
        run_seq(400);
        $display("[TB] test_random done, %0d pulses", pulse_cyc.size());
    endtask

    task automatic test_throughput();
        dsel = 2'd2;
        for (int i = 0; i < 8; i++) add(1'b0, 32'h800 + 32'(i*4), 4'h0, 32'h0);
        run_seq(200);
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            tests_run++;
            if (pulse_cyc[i] - pulse_cyc[i-1] != 2) begin
                tests_failed++;
                $display("FAIL throughput_gap[%0d]: got %0d expected 2", i, pulse_cyc[i] - pulse_cyc[i-1]);
            end
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy_s !== 1'b0) begin tests_failed++; $display("FAIL busy_after_last: got %b expected 0", busy_s); end
        $display("[TB] test_throughput pulses=%0d", pulse_cyc.size());
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_merge();
        test_back_pressure();
        test_alias();
        test_reset_midflight();
        test_random();
        test_throughput();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side memory responder: the slave end of the SRAM-like data bus driven by the MEM stage (req, wr, size, addr, byte strobes, wdata).
- Accepts requests with an addr_ok handshake and queues them in order.
- Services each request after a programmable latency and returns completion with a one-cycle data_ok pulse, plus a full 32-bit word for reads.
- Used as the simulation and FPGA data memory behind the CPU kernel. Byte extraction and sign extension for loads stay in the CPU.

Parameters:
- ADDR_W, 16, byte-address bits decoded. Memory holds 2^(ADDR_W-2) 32-bit words.
- LATENCY, 2, cycles from a request reaching queue head to its data_ok. Legal range 1..15.
- QDEPTH, 2, request queue depth. Must be a power of two, ≥1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request valid.
- wr  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word. Informational only; captured and exposed for checking.
- addr  in  32  byte address. Only bits [ADDR_W-1:2] are used.
- sel  in  4  byte write strobes, lane 0 = bits [7:0].
- wdata  in  32  store data, already lane-aligned.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle completion pulse, in request order.
- rdata  out  32  read word; valid when data_ok is high on a load.
- busy  out  1  queue non-empty or a request in service.

Behaviour:
- Reset values (asynchronous): queue empty, state IDLE, counter 0, data_ok 0, rdata 0, busy 0. Memory array is not reset.
- addr_ok is combinational: ~queue_full. It is 1 out of reset. It does not depend on req.
- Acceptance: req & addr_ok at a rising edge pushes {wr, size, word index, sel, wdata} into the queue. No other input is sampled.
- FSM states:
  - IDLE: queue empty. On a non-empty queue, load counter = LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. When counter == 0, perform the head access and go to RESP.
  - RESP: assert data_ok for exactly this cycle and pop the head. If the queue is still non-empty, reload the counter and go to WAIT; otherwise go to IDLE.
- Consequence for latency: with LATENCY=1 and an idle queue, a request accepted at edge N produces data_ok in the cycle after edge N+2.
- Access rules:
  - Store: for each i, mem[idx] byte i ← wdata byte i when sel[i]. sel=0000 is a legal no-op store that still returns data_ok.
  - Load: rdata ← mem[idx], whole word, registered. rdata holds its value until the next load completes.
  - Store completions leave rdata unchanged.
- Ordering: strictly in order. A load after a store to the same word returns the merged data.
- Wrap-around:
  - Queue pointers are log2(QDEPTH)+1 bits; full = MSBs differ and LSBs equal.
  - Addresses ≥ 2^ADDR_W alias to the low ADDR_W bits with no error.
- Simultaneous push and pop in RESP with a full queue:
  - addr_ok is still 0 in that cycle (full is evaluated before the pop); there is no bypass.
  - The next cycle shows addr_ok=1.
- Misaligned addresses (addr[1:0] ≠ 0) are not checked here. Alignment exceptions are already raised upstream.
- Reset mid-operation:
  - Pending requests are discarded and no data_ok is issued for them.
  - A store not yet in RESP is not written.
  - Memory keeps its prior contents.
- busy = (state != IDLE) | ~queue_empty.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - packed struct dmem_req_t {wr, size, idx, sel, wdata}.
  - FSM enum {IDLE, WAIT, RESP}.
- One natural sub-module: dmem_req_fifo, a parameterised synchronous FIFO of dmem_req_t with full/empty outputs and asynchronous reset.
- The memory array and FSM stay in the top level.

Test Plan:
- Word store then load, LATENCY=2: store 0x12345678 to 0x100 with sel=1111, then load 0x100. Require two data_ok pulses in order and rdata=0x12345678 on the second.
- Byte merge:
  - Preload word 0x200 = 0xAABBCCDD.
  - Store wdata=0x00001100 with sel=0010, then load 0x200.
  - Require rdata=0xAABB11DD.
- Back-pressure, QDEPTH=2, LATENCY=3: hold req high with 4 back-to-back loads.
  - addr_ok must drop to 0 after 2 acceptances.
  - Exactly 4 data_ok pulses in issue order, each separated by ≥3 cycles.
- Aliasing, ADDR_W=16: store 0xCAFEF00D to 0x00010004, then load 0x00000004. Require rdata=0xCAFEF00D.
- Reset mid-flight: accept a store of 0xFFFFFFFF to 0x300 (old value 0x0), then assert rst in WAIT.
  - No data_ok.
  - addr_ok=1 and busy=0 immediately on reset.
  - A later load of 0x300 returns 0x00000000.
- LATENCY=1 throughput: 8 sequential loads. Require data_ok every 2 cycles at steady state and busy deasserted the cycle after the last pulse.
